serial_mult_ctrl: RTL
=====================

# serial_mult_ctrl

Sequencing controller for the 16-bit multiplier datapath. It accepts two unsigned operands as a serial bit stream, assembling each one as a SIPO-style shift register. It then runs a radix-2 shift-add multiply over WIDTH cycles and presents the 2·WIDTH-bit product on a valid/ready output port. It sits between the serial input front end and the downstream consumer of multiplier results, and owns the single shared adder/shift datapath.

## Interface
- WIDTH, 16, operand width in bits; legal values 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; all state is cleared while rst=0.
- abort  input  1  synchronous clear; returns the block to IDLE on the next edge.
- sin_valid  input  1  serial bit present on sin_data.
- sin_data  input  1  serial operand bit.
- sin_ready  output  1  block can accept a serial bit.
- prod_valid  output  1  prod holds a finished result.
- prod_ready  input  1  consumer accepts prod.
- prod  output  2·WIDTH  unsigned product A·B.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD_A, LOAD_B, MULT, DONE. Bit counter is clog2(WIDTH+1) wide.
- A bit is accepted on a rising edge when sin_valid=1 and sin_ready=1. sin_ready=1 only in IDLE, LOAD_A and LOAD_B.
- IDLE: an accepted bit becomes the first bit of A; the state moves to LOAD_A with count=1.
- LOAD_A: each accepted bit is shifted into A. The WIDTH-th bit moves the state to LOAD_B with count=0.
- LOAD_B: each accepted bit is shifted into B. The WIDTH-th bit moves the state to MULT with count=0.
  - On entry to MULT: P[2W-1:0] = {W'b0, B}.
- Default bit order is MSB first. The operand register shifts left and the new bit enters the LSB, so after WIDTH bits the first bit sits in the MSB.
- Cycles with sin_valid=0 are gaps. Counters and registers hold through gaps, with no timeout.
- MULT, once per cycle:
  - If P[0]=1, compute {c, P[2W-1:W]} = P[2W-1:W] + A as a (W+1)-bit sum; otherwise c=0.
  - Then P = {c, P[2W-1:1]} (logical shift right, carry enters the MSB).
  - After WIDTH steps, P = A·B exactly, with no overflow possible. The state moves to DONE.
- DONE: prod_valid=1 and prod=P, held stable until prod_ready=1 on an edge; then the state returns to IDLE. prod_ready is ignored in all other states.
- abort=1 on an edge, from any state: next state is IDLE, counters are 0 and prod_valid=0. prod keeps its value but is not valid. abort takes priority over a simultaneous bit acceptance or product handshake.
- Reset (rst=0, any time, including mid-load or mid-multiply): state=IDLE, A=B=P=0, count=0.
- Reset values of outputs: sin_ready=1, prod_valid=0, prod=0, busy=0.

## Timing
- sin_ready, busy and prod_valid are decoded from registered state only; there is no combinational path from any input.
- Minimum operand load is 2·WIDTH cycles, one bit per cycle with no gaps.
- Product latency: if the last B bit is accepted at edge E0, MULT steps occur at edges E1..E_WIDTH. prod_valid is high after edge E_WIDTH, i.e. WIDTH cycles later (16 for the default).
- Back-to-back throughput: the next operand pair cannot start until the cycle after the DONE handshake. The minimum period is 3·WIDTH+1 cycles.
- prod changes only during MULT or at reset; it is stable whenever prod_valid=1.

## Configuration
- SERIAL_MULT_LSB_FIRST_EN defined: operands are received LSB first. The operand register shifts right and the new bit enters the MSB. The state machine, latency and product are otherwise unchanged.
- Not defined: MSB first, as described in Operation.

## Test plan
- MSB first, A=0x0003, B=0x0005, no gaps, prod_ready=1 → prod_valid rises 16 cycles after the last bit; prod=0x0000000F; busy falls the following cycle.
- A=0xFFFF, B=0xFFFF, random 1–3 cycle sin_valid gaps → prod=0xFFFE0001. sin_ready=0 throughout MULT and DONE.
- A=0x1234, B=0x0000, then prod_ready held low 5 cycles → prod=0 and prod_valid held high with prod stable for 5 cycles. Return to IDLE on the edge where prod_ready=1.
- rst pulsed low after 7 bits of B, then a new pair A=0x00FF, B=0x0101 → all outputs at reset values during reset; prod=0x0000FFFF. No residue from the aborted load.
- abort asserted in MULT step 8 together with sin_valid=1, then A=0x8000, B=0x0002 → IDLE next edge with prod_valid=0 and no bit accepted; next result is prod=0x00010000.
- With SERIAL_MULT_LSB_FIRST_EN, stream bits 1,1,0,…0 (A=3) and 1,0,1,0,…0 (B=5) → prod=0x0000000F. The same stream without the macro yields prod=0xC000·0xA000=0x78000000.

Source files
------------

// File: rtl/serial_mult_ctrl.sv
// Serial-load, radix-2 shift-add multiplier controller with valid/ready result port.
// Define SERIAL_MULT_LSB_FIRST_EN to receive operands LSB first (default MSB first).
module serial_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               sin_valid,
  input  logic               sin_data,
  output logic               sin_ready,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [2*WIDTH-1:0] p_reg, p_next;

  logic [WIDTH-1:0]   a_shift, b_shift;
  logic [WIDTH:0]     step_sum;
  logic               accept;
  logic               last_count;

  // Operand shift paths: the incoming bit enters the LSB (MSB-first stream)
  // or the MSB (LSB-first stream).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
`ifdef SERIAL_MULT_LSB_FIRST_EN
      assign a_shift[gi] = a_reg[gi+1];
      assign b_shift[gi] = b_reg[gi+1];
`else
      assign a_shift[gi+1] = a_reg[gi];
      assign b_shift[gi+1] = b_reg[gi];
`endif
    end
  endgenerate

`ifdef SERIAL_MULT_LSB_FIRST_EN
  assign a_shift[WIDTH-1] = sin_data;
  assign b_shift[WIDTH-1] = sin_data;
`else
  assign a_shift[0] = sin_data;
  assign b_shift[0] = sin_data;
`endif

  assign sin_ready  = (state_reg == IDLE) || (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign busy       = (state_reg != IDLE);
  assign prod_valid = (state_reg == DONE);
  assign prod       = p_reg;

  assign accept     = sin_valid && sin_ready;
  assign last_count = (count_reg == CW'(WIDTH - 1));
  assign step_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, a_reg};

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    if (abort) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_next     = a_shift;
            count_next = CW'(1);
            state_next = LOAD_A;
          end
        end
        LOAD_A: begin
          if (accept) begin
            a_next = a_shift;
            if (last_count) begin
              count_next = '0;
              state_next = LOAD_B;
            end else begin
              count_next = count_reg + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_next = b_shift;
            if (last_count) begin
              count_next = '0;
              p_next     = {{WIDTH{1'b0}}, b_shift};
              state_next = MULT;
            end else begin
              count_next = count_reg + CW'(1);
            end
          end
        end
        MULT: begin
          // Carry out of the partial-sum add re-enters at the MSB on the shift.
          if (p_reg[0]) begin
            p_next = {step_sum, p_reg[WIDTH-1:1]};
          end else begin
            p_next = {1'b0, p_reg[2*WIDTH-1:1]};
          end
          if (last_count) begin
            count_next = '0;
            state_next = DONE;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        DONE: begin
          if (prod_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
    end
  end

endmodule
